// File: rtl/pcg_unpermute.sv
// pcg_unpermute: recovers a 128-bit PCG state from its permuted output (un-rotate, then iterative inverse xorshift-right-6).
// Optional tag register and mismatch flag on out_rot_err are enabled by defining PCG_UNPERM_TAGCHECK_EN.
module pcg_unpermute #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [6:0]   in_rot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_rot_err,
  output logic         busy
);

  localparam int ITERS = 21;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t       r_state;
  state_t       w_stateNext;
  logic [127:0] r_work;
  logic [127:0] r_y;
  logic [4:0]   r_cnt;
  logic [255:0] w_rotDbl;
  logic [127:0] w_unrot;
  logic [127:0] w_iter;
  logic [5:0]   w_cntSum;

  // Rotating a doubled word keeps in_rot=0 a clean identity with no shift-by-128 case.
  assign w_rotDbl = {in_data, in_data} << in_rot;
  assign w_unrot  = w_rotDbl[255:128];

  always_comb begin
    w_iter = r_work;
    for (int i = 0; i < UNROLL; i++) begin
      w_iter = r_y ^ (w_iter >> 6);
    end
  end

  assign w_cntSum = {1'b0, r_cnt} + 6'(UNROLL);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_stateNext = ITER;
      ITER:    if (w_cntSum >= 6'(ITERS)) w_stateNext = DONE;
      DONE:    if (out_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_y    <= w_unrot;
            r_work <= w_unrot;
            r_cnt  <= '0;
          end
        end
        ITER: begin
          r_work <= w_iter;
          r_cnt  <= w_cntSum[4:0];
        end
        default: ;
      endcase
    end
  end

`ifdef PCG_UNPERM_TAGCHECK_EN
  logic [6:0] r_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_tag <= in_rot;
    end
  end

  assign out_rot_err = (r_state == DONE) && (r_work[127:121] != r_tag);
`else
  assign out_rot_err = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_work;

endmodule

// File: doc/pcg_unpermute.md
Name: pcg_unpermute

Overview:
- Inverse of the 128-bit PCG output permutation: forward transform is xorshift-right-6, then rotate-right by a 7-bit tag taken from the pre-permutation state's bits [127:121].
- Given a permuted word plus its rotation tag (carried alongside on the link), this block recovers the original 128-bit state.
- Sits on the receive/verify side of the PRNG datapath, e.g. for state recovery and self-check.
- Multi-cycle, iterative; valid/ready handshakes on both sides.

Parameters:
- UNROLL, 1, inverse-xorshift iterations per ITER cycle; legal 1..21.
- ITERS, 21, total inverse iterations required, ceil(128/6)-1; localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input word/tag valid
- in_ready  out  1  block can accept input
- in_data  in  128  permuted word
- in_rot  in  7  rotation tag used by the forward permutation
- out_valid  out  1  recovered state valid
- out_ready  in  1  downstream accepts output
- out_data  out  128  recovered pre-permutation state
- out_rot_err  out  1  recovered bits [127:121] differ from tag; qualified by out_valid
- busy  out  1  high in ITER or DONE

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; work, y, tag, cnt cleared to 0.
  - out_valid=0, out_data=0, out_rot_err=0, in_ready=1, busy=0.
- Un-rotate:
  - y = rotate-left(in_data, in_rot).
  - in_rot=0 gives identity; no shift-by-128 artefact allowed.
- Inverse xorshift:
  - x_{n+1} = y ^ (x_n >> 6), with x_0 = y.
  - After n iterations the top 6(n+1) bits are exact; after 21 iterations the full 128 bits are exact.
  - Extra iterations are harmless (fixed point).
- FSM:
  - IDLE: in_ready=1. On in_valid: y<=un-rotated word; work<=same; tag<=in_rot; cnt<=0; go to ITER.
  - ITER: in_ready=0. work <= UNROLL chained iterations; cnt<=cnt+UNROLL. When cnt+UNROLL >= ITERS, go to DONE.
  - DONE: out_valid=1; out_data=work; out_rot_err=(work[127:121]!=tag). Outputs hold stable while out_ready=0. On out_ready, go to IDLE next cycle and drop out_valid.
- Latency and throughput:
  - Accept edge T; out_valid rises after edge T+ceil(ITERS/UNROLL).
  - UNROLL=1: 21 cycles latency; one result per 23 cycles minimum (accept + 21 ITER + DONE handshake).
- Input side:
  - No input accepted outside IDLE; in_valid there is ignored and no data is lost (in_ready low).
  - in_data/in_rot are sampled only on the accept edge; later changes are ignored.
- Output side:
  - out_data/out_rot_err are undefined-but-stable (registered work) while out_valid=0; the bench checks them only with out_valid=1.
- Reset mid-operation: abort immediately to the reset values; the in-flight word is discarded.
- cnt width: 5 bits, saturating logic not needed because ITERS < 32.

Optional Feature:
- Macro: PCG_UNPERM_TAGCHECK_EN.
- Defined:
  - out_rot_err computed as above.
  - Tag comparator and tag register are present.
- Undefined:
  - out_rot_err tied to 0.
  - tag register and comparator removed.
  - out_data and timing identical.

Test Plan:
- Reset: assert rst low mid-ITER -> out_valid=0, out_data=0, in_ready=1, busy=0 immediately; the next accepted word completes normally.
- Single bit: in_data=128'h0000_0000_0000_0000_8200_0000_0000_0000, in_rot=64 -> out_data=128'h8000_0000_0000_0000_0000_0000_0000_0000, out_rot_err=0; out_valid asserts 21 cycles after accept (UNROLL=1).
- Tag mismatch: same in_data with in_rot=1, macro defined -> out_rot_err=1; macro undefined -> out_rot_err=0.
- Zero/identity: in_data=0, in_rot=0 -> out_data=0, out_rot_err=0. in_data=all-ones, in_rot=0 -> out_data equals the bench model's inverse, i.e. forward(out_data) == all-ones.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_data stable; in_ready=0; a new in_valid is not accepted until one cycle after the out_ready handshake.
- Round-trip: 1000 random states s through the bench model forward(s) with tag=s[127:121], UNROLL=1 and UNROLL=4 -> out_data==s, out_rot_err=0. Latency checks: 21 cycles for UNROLL=1, 6 cycles for UNROLL=4.
